hex_entry_pad: RTL and testbench

//  User-input end of the board front panel: the 7-seg path shows CPU values to the user; this block takes

---
 rtl/hex_entry_pad.sv | 188 ++++++++++++++++++
 tb/tb_hex_entry_pad.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_entry_pad.sv
// Front-panel hex entry: debounced push/clear/commit buttons assemble a
// word from switch nibbles and hand it downstream over valid/ready.

module hex_entry_debounce #(
   parameter int CYCLES = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic press_o
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

   logic          level_q;
   logic          level_d;
   logic          press_q;
   logic          press_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Any sample agreeing with the accepted level restarts the run.
   always_comb begin
      level_d = level_q;
      press_d = 1'b0;
      cnt_d   = '0;
      if (raw_i != level_q) begin
         if (cnt_q == LAST) begin
            level_d = raw_i;
            press_d = raw_i;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign press_o = press_q;

endmodule

module hex_entry_pad #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int DIGITS          = 8
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic [3:0]          SW,
   input  logic                BtnPush,
   input  logic                BtnClear,
   input  logic                BtnCommit,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [4*DIGITS-1:0] out_data,
   output logic [4*DIGITS-1:0] entry_val,
   output logic [3:0]          digit_count,
   output logic                entry_err
);

   localparam int W = 4 * DIGITS;
   localparam logic [3:0] MAXD = 4'(DIGITS);

   typedef enum logic {
      ENTRY,
      HOLD
   } state_t;

   logic [6:0]   meta_q;
   logic [6:0]   sync_q;
   logic [2:0]   press;
   logic         push_p;
   logic         clr_p;
   logic         cmt_p;
   logic [3:0]   sw_s;

   state_t       state_q;
   state_t       state_d;
   logic [W-1:0] entry_q;
   logic [W-1:0] entry_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;
   logic [3:0]   count_q;
   logic [3:0]   count_d;
   logic         err_q;
   logic         err_d;

   // Two-stage synchronizer: {commit, clear, push, SW}
   always_ff @(posedge clk) begin
      if (Reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {BtnCommit, BtnClear, BtnPush, SW};
         sync_q <= meta_q;
      end
   end

   assign sw_s = sync_q[3:0];

   for (genvar i = 0; i < 3; i++) begin : g_db
      hex_entry_debounce #(
         .CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk_i   (clk),
         .rst_i   (Reset),
         .raw_i   (sync_q[4+i]),
         .press_o (press[i])
      );
   end

   assign push_p = press[0];
   assign clr_p  = press[1];
   assign cmt_p  = press[2];

   // Clear beats commit beats push; HOLD ignores all buttons.
   always_comb begin
      state_d = state_q;
      entry_d = entry_q;
      data_d  = data_q;
      count_d = count_q;
      err_d   = 1'b0;
      unique case (state_q)
         ENTRY: begin
            if (clr_p) begin
               entry_d = '0;
               count_d = '0;
            end else if (cmt_p) begin
               if (count_q != 4'd0) begin
                  data_d  = entry_q;
                  state_d = HOLD;
               end else begin
                  err_d = 1'b1;
               end
            end else if (push_p) begin
               if (count_q < MAXD) begin
                  entry_d = {entry_q[W-5:0], sw_s};
                  count_d = count_q + 4'd1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = ENTRY;
               entry_d = '0;
               count_d = '0;
            end
         end
         default: state_d = ENTRY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q <= ENTRY;
         entry_q <= '0;
         data_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         entry_q <= entry_d;
         data_q  <= data_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign out_valid   = (state_q == HOLD);
   assign out_data    = data_q;
   assign entry_val   = entry_q;
   assign digit_count = count_q;
   assign entry_err   = err_q;

endmodule

// File: tb/tb_hex_entry_pad.sv
// Scenario bench for hex_entry_pad with short debounce; committed words
// are scoreboarded and matched at each valid/ready transfer.

module tb_hex_entry_pad;

   localparam int DEB = 4;
   localparam int DIG = 8;
   localparam int W   = 4 * DIG;

   logic         clk = 1'b0;
   logic         Reset = 1'b1;
   logic [3:0]   SW = '0;
   logic         BtnPush = 1'b0;
   logic         BtnClear = 1'b0;
   logic         BtnCommit = 1'b0;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic [W-1:0] entry_val;
   logic [3:0]   digit_count;
   logic         entry_err;

   int passed = 0;
   int total = 0;
   int err_cnt = 0;
   int valid_cycles = 0;
   logic [W-1:0] sb[$];

   always #5 clk = ~clk;

   hex_entry_pad #(
      .DEBOUNCE_CYCLES (DEB),
      .DIGITS          (DIG)
   ) dut (
      .clk         (clk),
      .Reset       (Reset),
      .SW          (SW),
      .BtnPush     (BtnPush),
      .BtnClear    (BtnClear),
      .BtnCommit   (BtnCommit),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .entry_val   (entry_val),
      .digit_count (digit_count),
      .entry_err   (entry_err)
   );

   always @(negedge clk) begin
      logic [W-1:0] exp_w;
      if (!Reset) begin
         if (entry_err) err_cnt++;
         if (out_valid) valid_cycles++;
         if (out_valid && out_ready) begin
            total++;
            if (sb.size() == 0) begin
               $display("FAIL sb_underflow: out_data=%h, no word expected", out_data);
            end else begin
               exp_w = sb.pop_front();
               if (out_data !== exp_w)
                  $display("FAIL sb_data: got %h want %h", out_data, exp_w);
               else
                  passed++;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // mask bit0=push, bit1=clear, bit2=commit; clean press then release
   task automatic press(input logic [2:0] m);
      BtnPush   = m[0];
      BtnClear  = m[1];
      BtnCommit = m[2];
      tick(10);
      BtnPush   = 1'b0;
      BtnClear  = 1'b0;
      BtnCommit = 1'b0;
      tick(10);
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick(3);
      Reset = 1'b0;
      tick(1);
      total++;
      if ({out_valid, entry_err} !== 2'b00)
         $display("FAIL rst_flags: got %b want 00", {out_valid, entry_err});
      else passed++;
      total++;
      if (out_data !== '0 || entry_val !== '0)
         $display("FAIL rst_words: got %h/%h want 0/0", out_data, entry_val);
      else passed++;
      total++;
      if (digit_count !== 4'd0)
         $display("FAIL rst_count: got %0d want 0", digit_count);
      else passed++;
   endtask

   task automatic test_fill();
      int e0;
      e0 = err_cnt;
      for (int i = 1; i <= 8; i++) begin
         SW = 4'(i);
         press(3'b001);
      end
      total++;
      if (entry_val !== 32'h12345678)
         $display("FAIL fill_val: got %h want 12345678", entry_val);
      else passed++;
      total++;
      if (digit_count !== 4'd8)
         $display("FAIL fill_count: got %0d want 8", digit_count);
      else passed++;
      total++;
      if (err_cnt !== e0)
         $display("FAIL fill_err: got %0d pulses want 0", err_cnt - e0);
      else passed++;
   endtask

   task automatic test_full_hold();
      int e0;
      int bad;
      e0 = err_cnt;
      SW = 4'h9;
      press(3'b001);
      total++;
      if (entry_val !== 32'h12345678 || digit_count !== 4'd8)
         $display("FAIL full_push: got %h/%0d want 12345678/8", entry_val, digit_count);
      else passed++;
      total++;
      if (err_cnt !== e0 + 1)
         $display("FAIL full_err: got %0d pulses want 1", err_cnt - e0);
      else passed++;
      out_ready = 1'b0;
      sb.push_back(32'h12345678);
      press(3'b100);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h12345678)
         $display("FAIL hold_enter: got %b/%h want 1/12345678", out_valid, out_data);
      else passed++;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (out_valid !== 1'b1 || out_data !== 32'h12345678) bad++;
      end
      total++;
      if (bad != 0)
         $display("FAIL hold_stable: got %0d bad cycles want 0", bad);
      else passed++;
      out_ready = 1'b1;
      tick(1);
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || entry_val !== '0 || digit_count !== 4'd0)
         $display("FAIL hold_release: got %b/%h/%0d want 0/0/0",
                  out_valid, entry_val, digit_count);
      else passed++;
      total++;
      if (sb.size() != 0)
         $display("FAIL hold_sb: got %0d pending want 0", sb.size());
      else passed++;
   endtask

   task automatic test_bouncy();
      SW = 4'h7;
      for (int i = 0; i < 10; i++) begin
         BtnPush = ~BtnPush;
         tick(2);
      end
      BtnPush = 1'b1;
      tick(10);
      BtnPush = 1'b0;
      tick(10);
      total++;
      if (digit_count !== 4'd1 || entry_val !== 32'h7)
         $display("FAIL bouncy: got %0d/%h want 1/00000007", digit_count, entry_val);
      else passed++;
   endtask

   task automatic test_commit_empty();
      int e0;
      int v0;
      press(3'b010);
      total++;
      if (digit_count !== 4'd0 || entry_val !== '0)
         $display("FAIL clear: got %0d/%h want 0/0", digit_count, entry_val);
      else passed++;
      e0 = err_cnt;
      v0 = valid_cycles;
      press(3'b100);
      total++;
      if (err_cnt !== e0 + 1)
         $display("FAIL empty_err: got %0d pulses want 1", err_cnt - e0);
      else passed++;
      total++;
      if (valid_cycles !== v0)
         $display("FAIL empty_valid: got %0d valid cycles want 0", valid_cycles - v0);
      else passed++;
      SW = 4'hA;
      press(3'b001);
      total++;
      if (entry_val !== 32'hA || digit_count !== 4'd1)
         $display("FAIL enter_a: got %h/%0d want 0000000a/1", entry_val, digit_count);
      else passed++;
      press(3'b110);
      total++;
      if (entry_val !== '0 || digit_count !== 4'd0)
         $display("FAIL clr_cmt: got %h/%0d want 0/0", entry_val, digit_count);
      else passed++;
      total++;
      if (valid_cycles !== v0 || err_cnt !== e0 + 1)
         $display("FAIL clr_cmt_side: got %0d valid %0d err want 0 0",
                  valid_cycles - v0, err_cnt - e0 - 1);
      else passed++;
   endtask

   task automatic test_hold_reset();
      int e0;
      out_ready = 1'b0;
      SW = 4'h3;
      press(3'b001);
      sb.push_back(32'h3);
      press(3'b100);
      total++;
      if (out_valid !== 1'b1 || out_data !== 32'h3)
         $display("FAIL hr_enter: got %b/%h want 1/00000003", out_valid, out_data);
      else passed++;
      e0 = err_cnt;
      SW = 4'hF;
      press(3'b001);
      press(3'b010);
      total++;
      if (out_data !== 32'h3 || entry_val !== 32'h3 || digit_count !== 4'd1)
         $display("FAIL hr_ignore: got %h/%h/%0d want 3/3/1",
                  out_data, entry_val, digit_count);
      else passed++;
      total++;
      if (out_valid !== 1'b1 || err_cnt !== e0)
         $display("FAIL hr_noerr: got %b/%0d want 1/0", out_valid, err_cnt - e0);
      else passed++;
      Reset = 1'b1;
      tick(1);
      Reset = 1'b0;
      sb.delete();
      total++;
      if (out_valid !== 1'b0 || entry_err !== 1'b0 || digit_count !== 4'd0)
         $display("FAIL hr_rst_flags: got %b/%b/%0d want 0/0/0",
                  out_valid, entry_err, digit_count);
      else passed++;
      total++;
      if (out_data !== '0 || entry_val !== '0)
         $display("FAIL hr_rst_words: got %h/%h want 0/0", out_data, entry_val);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] nib [4];
      int v0;
      nib = '{4'hB, 4'hE, 4'hE, 4'hF};
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         SW = nib[i];
         press(3'b001);
      end
      total++;
      if (entry_val !== 32'h0000BEEF || digit_count !== 4'd4)
         $display("FAIL tied_entry: got %h/%0d want 0000beef/4", entry_val, digit_count);
      else passed++;
      sb.push_back(32'h0000BEEF);
      v0 = valid_cycles;
      press(3'b100);
      total++;
      if (valid_cycles - v0 !== 1)
         $display("FAIL tied_width: got %0d valid cycles want 1", valid_cycles - v0);
      else passed++;
      total++;
      if (sb.size() != 0 || out_valid !== 1'b0 || entry_val !== '0)
         $display("FAIL tied_after: got %0d/%b/%h want 0/0/0",
                  sb.size(), out_valid, entry_val);
      else passed++;
      out_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_full_hold();
      test_bouncy();
      test_commit_empty();
      test_hold_reset();
      test_back_to_back();
      tick(2);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
